maze_mem: RTL and testbench

MAZE_MEM -- requirements
Module: maze_mem

---
 rtl/maze_mem.sv | 158 +++++++++++++++
 tb/tb_maze_mem.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_mem.sv
// Maze cell store for a path solver: bulk row-major load of wall/free cells,
// then single-cycle reads and mark-visited writes addressed by (row, col).
// Cells are 2-bit codes FREE/WALL/VISITED; code 3 is never written.
module maze_mem #(
  parameter int DIM = 64,
  localparam int IW = $clog2(DIM),
  localparam int AW = 2 * IW,
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] row,
  input  logic [IW-1:0] col,
  input  logic          maze_oe,
  input  logic          maze_we,
  output logic          maze_in,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic          load_data,
  output logic          load_ready,
  output logic          load_done,
  output logic [CW-1:0] visit_count,
  output logic          we_wall_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SERVE} state_t;

  localparam int            DEPTH   = DIM * DIM;
  localparam logic [1:0]    C_FREE  = 2'd0;
  localparam logic [1:0]    C_WALL  = 2'd1;
  localparam logic [1:0]    C_VISIT = 2'd2;
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [CW-1:0] VC_MAX  = CW'(DEPTH - 1);

  // Reset asserts asynchronously but releases on a clock edge; until this
  // flop sets, the control state is held at its reset values.
  logic rst_sync_q;

  // Reset release synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 1'b0;
    else        rst_sync_q <= 1'b1;
  end

  // Cell storage, no reset: contents are only meaningful after a full load.
  logic [1:0]    cells [DEPTH];
  logic [AW-1:0] cell_idx;
  logic [1:0]    cur;

  assign cell_idx = {row, col};
  assign cur      = cells[cell_idx];

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] vc_q, vc_d;
  logic          maze_in_q, maze_in_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_wdata;

  // Next-state logic: load_start wins over everything, including the
  // solver ports in SERVE and a coincident load beat in LOAD.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    vc_d      = vc_q;
    maze_in_d = maze_in_q;
    err_d     = err_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = C_FREE;
    if (load_start) begin
      state_d   = S_LOAD;
      addr_d    = '0;
      vc_d      = '0;
      err_d     = 1'b0;
      maze_in_d = 1'b1;
    end else begin
      case (state_q)
        S_LOAD: begin
          maze_in_d = 1'b1;
          if (load_valid) begin
            mem_we    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = load_data ? C_WALL : C_FREE;
            addr_d    = addr_q + AW'(1);
            if (addr_q == LAST) begin
              state_d = S_SERVE;
              done_d  = 1'b1;
            end
          end
        end
        S_SERVE: begin
          // Read samples the pre-write content of the same cell.
          if (maze_oe) maze_in_d = (cur != C_FREE);
          if (maze_we) begin
            if (cur == C_FREE) begin
              mem_we    = 1'b1;
              mem_addr  = cell_idx;
              mem_wdata = C_VISIT;
              if (vc_q != VC_MAX) vc_d = vc_q + CW'(1);
            end else if (cur == C_WALL) begin
              err_d = 1'b1;
            end
          end
        end
        default: maze_in_d = 1'b1;
      endcase
    end
    ready_d = (state_d == S_LOAD);
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      vc_q      <= '0;
      maze_in_q <= 1'b1;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else if (!rst_sync_q) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      vc_q      <= '0;
      maze_in_q <= 1'b1;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      vc_q      <= vc_d;
      maze_in_q <= maze_in_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Cell array write port (load beats and mark-visited)
  always_ff @(posedge clk) begin
    if (mem_we && rst_sync_q) cells[mem_addr] <= mem_wdata;
  end

  assign maze_in     = maze_in_q;
  assign load_ready  = ready_q;
  assign load_done   = done_q;
  assign visit_count = vc_q;
  assign we_wall_err = err_q;

endmodule

// File: tb/tb_maze_mem.sv
// Bench for maze_mem: random load data and solver traffic compared each
// cycle against a cell-array model, plus hand-computed directed checks.
module tb_maze_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [5:0]  row = '0;
  logic [5:0]  col = '0;
  logic        maze_oe = 1'b0;
  logic        maze_we = 1'b0;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_data = 1'b0;
  logic        maze_in;
  logic        load_ready;
  logic        load_done;
  logic [12:0] visit_count;
  logic        we_wall_err;

  int n_chk = 0;
  int n_err = 0;

  maze_mem #(.DIM(64)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col),
    .maze_oe(maze_oe), .maze_we(maze_we), .maze_in(maze_in),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done),
    .visit_count(visit_count), .we_wall_err(we_wall_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: cells as 0 free / 1 wall / 2 visited, load progress as an index.
  int m_cell [4096];
  bit m_loading = 0, m_serving = 0, m_armed = 0;
  bit m_mi = 1, m_done = 0, m_err = 0;
  int m_addr = 0, m_vc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loading = 0; m_serving = 0; m_armed = 0;
      m_mi = 1; m_done = 0; m_err = 0; m_addr = 0; m_vc = 0;
    end else if (!m_armed) begin
      m_armed = 1;
    end else begin
      int idx;
      idx = int'(row) * 64 + int'(col);
      m_done = 0;
      if (load_start) begin
        m_loading = 1; m_serving = 0; m_addr = 0; m_vc = 0; m_err = 0; m_mi = 1;
      end else if (m_loading) begin
        m_mi = 1;
        if (load_valid) begin
          m_cell[m_addr] = int'(load_data);
          if (m_addr == 4095) begin
            m_loading = 0; m_serving = 1; m_done = 1;
          end else begin
            m_addr++;
          end
        end
      end else if (m_serving) begin
        if (maze_oe) m_mi = (m_cell[idx] != 0);
        if (maze_we) begin
          if (m_cell[idx] == 0) begin
            m_cell[idx] = 2;
            if (m_vc < 4095) m_vc++;
          end else if (m_cell[idx] == 1) begin
            m_err = 1;
          end
        end
      end
    end
  end

  // Every-cycle comparison, away from the active edge
  always @(negedge clk) begin
    chk("maze_in", int'(maze_in), int'(m_mi));
    chk("load_ready", int'(load_ready), int'(m_loading));
    chk("load_done", int'(load_done), int'(m_done));
    chk("visit_count", int'(visit_count), m_vc);
    chk("we_wall_err", int'(we_wall_err), int'(m_err));
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // kind 0: border walls except (0,5); 1: random 25% walls; 2: all free
  function automatic bit pat(input int kind, input int a);
    int r, c;
    r = a / 64;
    c = a % 64;
    case (kind)
      0:       return (r == 0 || r == 63 || c == 0 || c == 63) && !(r == 0 && c == 5);
      2:       return 1'b0;
      default: return ($urandom_range(0, 3) == 0);
    endcase
  endfunction

  task automatic start_load();
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
  endtask

  task automatic beats(input int kind, input int from, input int n, output int rdy);
    rdy = 0;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        load_valid = 1'b0;
        cyc();
      end
      if (load_ready) rdy++;
      load_valid = 1'b1;
      load_data  = pat(kind, from + i);
      cyc();
    end
    load_valid = 1'b0;
  endtask

  task automatic serve_rand(input int n);
    for (int i = 0; i < n; i++) begin
      maze_oe = 1'($urandom_range(0, 1));
      maze_we = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) != 0) begin
        row = 6'($urandom);
        col = 6'($urandom);
      end
      cyc();
    end
    maze_oe = 1'b0;
    maze_we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy;
    #1 rst_n = 1'b0;
    repeat (3) cyc();
    chk("rst_maze_in", int'(maze_in), 1);
    chk("rst_load_ready", int'(load_ready), 0);
    chk("rst_visit_count", int'(visit_count), 0);
    chk("rst_err", int'(we_wall_err), 0);
    rst_n = 1'b1;
    cyc();
    chk("first_edge_idle", int'(load_ready), 0);
    cyc();

    // Full load: border walls with an opening at (0,5)
    start_load();
    chk("load1_ready_up", int'(load_ready), 1);
    beats(0, 0, 4096, rdy);
    chk("load1_ready_beats", rdy, 4096);
    chk("load1_done", int'(load_done), 1);
    chk("load1_ready_off", int'(load_ready), 0);
    cyc();
    chk("load1_done_pulse", int'(load_done), 0);

    // Reads: wall then opening, one cycle latency each
    row = 0; col = 0; maze_oe = 1'b1;
    cyc();
    chk("rd_0_0", int'(maze_in), 1);
    col = 5;
    cyc();
    chk("rd_0_5", int'(maze_in), 0);
    maze_oe = 1'b0;
    cyc();
    chk("rd_hold", int'(maze_in), 0);

    // Double write to a free cell counts once
    row = 10; col = 10; maze_we = 1'b1;
    cyc();
    cyc();
    maze_we = 1'b0;
    chk("visit_once", int'(visit_count), 1);
    maze_oe = 1'b1;
    cyc();
    maze_oe = 1'b0;
    chk("visited_reads_1", int'(maze_in), 1);

    // Write to a wall
    row = 0; col = 0; maze_we = 1'b1;
    cyc();
    maze_we = 1'b0;
    chk("wall_err_set", int'(we_wall_err), 1);
    maze_oe = 1'b1;
    cyc();
    maze_oe = 1'b0;
    chk("wall_still_1", int'(maze_in), 1);
    chk("wall_no_count", int'(visit_count), 1);

    // Read-before-write on the same free cell
    row = 20; col = 20; maze_oe = 1'b1; maze_we = 1'b1;
    cyc();
    maze_we = 1'b0;
    chk("rbw_old", int'(maze_in), 0);
    chk("rbw_count", int'(visit_count), 2);
    cyc();
    maze_oe = 1'b0;
    chk("rbw_new", int'(maze_in), 1);

    serve_rand(1500);

    // Reload clears sticky error and count; restart mid-load at beat 2000
    start_load();
    chk("reload_err_clr", int'(we_wall_err), 0);
    chk("reload_vc_clr", int'(visit_count), 0);
    chk("reload_walls", int'(maze_in), 1);
    beats(1, 0, 2000, rdy);
    load_start = 1'b1; load_valid = 1'b1; load_data = 1'b1;
    cyc();
    load_start = 1'b0; load_valid = 1'b0;
    beats(1, 0, 4095, rdy);
    chk("restart_no_done", int'(load_done), 0);
    chk("restart_still_ready", int'(load_ready), 1);
    beats(1, 4095, 1, rdy);
    chk("restart_done", int'(load_done), 1);

    serve_rand(2000);

    // Reset mid-load
    start_load();
    beats(1, 0, 1000, rdy);
    #1 rst_n = 1'b0;
    #1;
    chk("async_ready_low", int'(load_ready), 0);
    chk("async_maze_in", int'(maze_in), 1);
    chk("async_vc", int'(visit_count), 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("post_rst_idle", int'(load_ready), 0);

    // All-free maze, visit every cell: count saturates at 4095
    start_load();
    beats(2, 0, 4096, rdy);
    maze_we = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      row = 6'(i / 64);
      col = 6'(i % 64);
      cyc();
      if (i == 99) chk("vc_100", int'(visit_count), 100);
    end
    maze_we = 1'b0;
    chk("vc_saturate", int'(visit_count), 4095);
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
